// File: rtl/mod257_accum.sv
// mod257_accum: streaming per-frame accumulator modulo 257 with saturating term count and range-error flag
module mod257_accum #(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic signed [14:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [8:0]        out_data,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_err
);
  typedef enum logic {IDLE, ACC} state_t;
  state_t            state_q, state_d;
  logic [8:0]        acc_q, acc_d, out_data_q, out_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, out_cnt_q, out_cnt_d, cnt_inc;
  logic              err_q, err_d, out_valid_q, out_valid_d, out_err_q, out_err_d;
  logic              accept, range_err;
  logic signed [15:0] sum;
  logic [8:0]        canon;
  assign in_ready  = ~out_valid_q | out_ready;
  assign accept    = in_valid & in_ready;
  assign sum       = $signed({7'b0, acc_q}) + $signed({in_data[14], in_data});
  // Illegal inputs can push sum outside [-255,767]; the result is then just the low 9 bits
  assign canon     = 9'(sum < 16'sd0   ? sum + 16'sd257 :
                         sum >= 16'sd514 ? sum - 16'sd514 :
                         sum >= 16'sd257 ? sum - 16'sd257 : sum);
  assign range_err = (in_data < -15'sd255) | (in_data > 15'sd511);
  assign cnt_inc   = &cnt_q ? cnt_q : cnt_q + 1'b1;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_cnt   = out_cnt_q;
  assign out_err   = out_err_q;
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    out_data_d  = out_data_q;
    out_cnt_d   = out_cnt_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q & ~out_ready;
    if (accept && in_last) begin
      state_d     = IDLE;
      acc_d       = '0;
      cnt_d       = '0;
      err_d       = 1'b0;
      out_data_d  = canon;
      out_cnt_d   = cnt_inc;
      out_err_d   = err_q | range_err;
      out_valid_d = 1'b1;
    end else if (accept) begin
      state_d = ACC;
      acc_d   = canon;
      cnt_d   = cnt_inc;
      err_d   = err_q | range_err;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_cnt_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_cnt_q   <= out_cnt_d;
      out_err_q   <= out_err_d;
    end
  end
endmodule

// File: tb/tb_mod257_accum.sv
// tb_mod257_accum: directed self-checking bench for mod257_accum
module tb_mod257_accum;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [14:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [8:0]        out_data;
  logic [7:0]        out_cnt;
  logic              out_err;
  int errors = 0;
  int checks = 0;

  mod257_accum #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_cnt(out_cnt), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // Called 1 time unit after a rising edge; returns 1 time unit after the next one
  task automatic beat(input int d, input logic last);
    in_valid = 1'b1;
    in_data  = 15'(d);
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++; if (out_data !== 9'd0) begin errors++; $display("FAIL reset_data got=%0d exp=0", out_data); end
    checks++; if (out_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", out_cnt); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", out_err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", in_ready); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_frame;
    out_ready = 1'b1;
    beat(300, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL frame_midvalid got=%0b exp=0", out_valid); end
    beat(300, 1'b0);
    beat(-10, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL frame_valid got=%0b exp=1", out_valid); end
    checks++; if (out_data !== 9'd76) begin errors++; $display("FAIL frame_data got=%0d exp=76", out_data); end
    checks++; if (out_cnt !== 8'd3) begin errors++; $display("FAIL frame_cnt got=%0d exp=3", out_cnt); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL frame_err got=%0b exp=0", out_err); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL frame_consumed got=%0b exp=0", out_valid); end
    checks++; if (out_data !== 9'd76) begin errors++; $display("FAIL frame_keep got=%0d exp=76", out_data); end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    beat(511, 1'b1);
    checks++; if (out_data !== 9'd254) begin errors++; $display("FAIL b2b_data0 got=%0d exp=254", out_data); end
    checks++; if (out_cnt !== 8'd1) begin errors++; $display("FAIL b2b_cnt0 got=%0d exp=1", out_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%0b exp=1", in_ready); end
    beat(-255, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid1 got=%0b exp=1", out_valid); end
    checks++; if (out_data !== 9'd2) begin errors++; $display("FAIL b2b_data1 got=%0d exp=2", out_data); end
    checks++; if (out_cnt !== 8'd1) begin errors++; $display("FAIL b2b_cnt1 got=%0d exp=1", out_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    beat(5, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got=%0b exp=1", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got=%0b exp=0", in_ready); end
    in_valid = 1'b1;
    in_data  = 15'sd9;
    in_last  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (out_data !== 9'd5) begin errors++; $display("FAIL bp_hold%0d got=%0d exp=5", i, out_data); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall%0d got=%0b exp=0", i, in_ready); end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    out_ready = 1'b1;
    beat(7, 1'b1);
    checks++; if (out_data !== 9'd7) begin errors++; $display("FAIL bp_next got=%0d exp=7", out_data); end
    checks++; if (out_cnt !== 8'd1) begin errors++; $display("FAIL bp_next_cnt got=%0d exp=1", out_cnt); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got=%0b exp=0", out_valid); end
  endtask

  task automatic test_range;
    out_ready = 1'b1;
    beat(600, 1'b0);
    beat(1, 1'b1);
    checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL range_err got=%0b exp=1", out_err); end
    checks++; if (out_cnt !== 8'd2) begin errors++; $display("FAIL range_cnt got=%0d exp=2", out_cnt); end
    checks++; if (out_data !== 9'd87) begin errors++; $display("FAIL range_data got=%0d exp=87", out_data); end
    beat(1, 1'b1);
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL range_clear got=%0b exp=0", out_err); end
    checks++; if (out_data !== 9'd1) begin errors++; $display("FAIL range_data2 got=%0d exp=1", out_data); end
    beat(-300, 1'b1);
    checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL range_neg_err got=%0b exp=1", out_err); end
    checks++; if (out_data !== 9'd469) begin errors++; $display("FAIL range_neg_data got=%0d exp=469", out_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation;
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) beat(1, 1'b0);
    beat(1, 1'b1);
    checks++; if (out_data !== 9'd0) begin errors++; $display("FAIL sat_data got=%0d exp=0", out_data); end
    checks++; if (out_cnt !== 8'd255) begin errors++; $display("FAIL sat_cnt got=%0d exp=255", out_cnt); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL sat_err got=%0b exp=0", out_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    beat(100, 1'b0);
    beat(100, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%0b exp=0", out_valid); end
    rst_n = 1'b1;
    out_ready = 1'b1;
    beat(3, 1'b1);
    checks++; if (out_data !== 9'd3) begin errors++; $display("FAIL rstmid_data got=%0d exp=3", out_data); end
    checks++; if (out_cnt !== 8'd1) begin errors++; $display("FAIL rstmid_cnt got=%0d exp=1", out_cnt); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_valid2 got=%0b exp=1", out_valid); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_frame;
    test_back_to_back;
    test_backpressure;
    test_range;
    test_saturation;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
